// File: rtl/mem_stage_ctrl.sv
// MEM-stage data-memory controller: alignment check, lane steering,
// wait/timeout handling and load extension into the WB registers.
module mem_stage_ctrl #(
    parameter int DW      = 32,
    parameter int CTRL_W  = 32,
    parameter int TIMEOUT = 15
) (
    input  logic              clk_cpu,
    input  logic              rst,
    input  logic              valid_m,
    input  logic [CTRL_W-1:0] ctrm,
    input  logic [DW-1:0]     y,
    input  logic [DW-1:0]     mdw,
    input  logic [31:0]       irm,
    input  logic              flush,
    input  logic [DW-1:0]     dm_rdata,
    input  logic              dm_ready,
    output logic              dm_req,
    output logic              dm_we,
    output logic [DW/8-1:0]   dm_be,
    output logic [DW-1:0]     dm_addr,
    output logic [DW-1:0]     dm_wdata,
    output logic [DW-1:0]     mdr,
    output logic [DW-1:0]     yw,
    output logic [31:0]       irw,
    output logic              valid_w,
    output logic              stall_m,
    output logic              misalign,
    output logic              timeout_err
);
    localparam int BW = DW / 8;
    localparam int OW = $clog2(BW);

    typedef enum logic {IDLE, ACCESS} state_t;
    state_t state, state_nxt;

    logic [7:0]    cnt;
    logic          flush_q;
    logic          st_q;
    logic          uns_q;
    logic [1:0]    sz_q;
    logic [OW-1:0] off_q;
    logic [BW-1:0] be_q;
    logic [DW-1:0] y_q;
    logic [31:0]   ir_q;

    logic          is_ld, is_st;
    logic          op_live, mem_op, aligned;
    logic [1:0]    sz;
    logic [OW-1:0] off;
    logic [BW-1:0] be_new;
    logic [DW-1:0] wdata_new;
    logic [DW-1:0] sh, ld_mask, ld_ext;
    logic          ld_sgn;
    logic          done, tmo;
    logic          unused_ctrl;

    assign unused_ctrl = ^{ctrm[CTRL_W-1:5], ctrm[0]};

    assign is_ld   = ctrm[1];
    assign is_st   = ctrm[2];
    assign op_live = valid_m && !flush;
    assign mem_op  = op_live && (is_ld || is_st);
    // A dword request on a 32-bit bus degrades to a full-word access
    assign sz      = (DW == 32 && ctrm[4:3] == 2'b11) ? 2'b10 : ctrm[4:3];
    assign off     = y[OW-1:0];

    always_comb begin
        aligned   = 1'b1;
        be_new    = '1;
        wdata_new = mdw;
        unique case (1'b1)
            sz == 2'b00: begin
                be_new    = BW'(1) << off;
                wdata_new = {BW{mdw[7:0]}};
            end
            sz == 2'b01: begin
                aligned   = ~y[0];
                be_new    = BW'(3) << off;
                wdata_new = {(DW/16){mdw[15:0]}};
            end
            sz == 2'b10: begin
                aligned   = (y[1:0] == 2'b00);
                be_new    = BW'(4'hF) << off;
                wdata_new = {(DW/32){mdw[31:0]}};
            end
            default: aligned = (y[2:0] == 3'b000);
        endcase
    end

    assign sh = dm_rdata >> {off_q, 3'b000};

    always_comb begin
        ld_mask = '1;
        ld_sgn  = 1'b0;
        unique case (1'b1)
            sz_q == 2'b00: begin
                ld_mask = DW'(8'hFF);
                ld_sgn  = sh[7];
            end
            sz_q == 2'b01: begin
                ld_mask = DW'(16'hFFFF);
                ld_sgn  = sh[15];
            end
            sz_q == 2'b10: begin
                ld_mask = DW'(32'hFFFF_FFFF);
                ld_sgn  = sh[31];
            end
            default: ;
        endcase
        ld_ext = (sh & ld_mask) | ({DW{ld_sgn & ~uns_q}} & ~ld_mask);
    end

    assign done = (state == ACCESS) && dm_ready;
    // Ready in the threshold cycle wins over the timeout
    assign tmo  = (state == ACCESS) && !dm_ready &&
                  (cnt == 8'(TIMEOUT - 1));

    always_comb begin
        state_nxt = state;
        stall_m   = 1'b0;
        dm_req    = 1'b0;
        dm_we     = 1'b0;
        dm_be     = '0;
        unique case (state)
            IDLE: begin
                stall_m = mem_op && aligned;
                if (mem_op && aligned)
                    state_nxt = ACCESS;
            end
            ACCESS: begin
                stall_m = !(done || tmo);
                dm_req  = 1'b1;
                dm_we   = st_q;
                dm_be   = be_q;
                if (done || tmo)
                    state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk_cpu or posedge rst) begin
        if (rst)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_ff @(posedge clk_cpu or posedge rst) begin
        if (rst) begin
            cnt         <= '0;
            flush_q     <= 1'b0;
            st_q        <= 1'b0;
            uns_q       <= 1'b0;
            sz_q        <= '0;
            off_q       <= '0;
            be_q        <= '0;
            y_q         <= '0;
            ir_q        <= '0;
            dm_addr     <= '0;
            dm_wdata    <= '0;
            mdr         <= '0;
            yw          <= '0;
            irw         <= '0;
            valid_w     <= 1'b0;
            misalign    <= 1'b0;
            timeout_err <= 1'b0;
        end else begin
            misalign    <= 1'b0;
            timeout_err <= 1'b0;
            unique case (state)
                IDLE: begin
                    valid_w <= 1'b0;
                    if (mem_op && !aligned) begin
                        misalign <= 1'b1;
                        mdr      <= '0;
                    end else if (mem_op) begin
                        dm_addr  <= {y[DW-1:OW], {OW{1'b0}}};
                        be_q     <= be_new;
                        dm_wdata <= wdata_new;
                        ir_q     <= irm;
                        y_q      <= y;
                        st_q     <= is_st;
                        uns_q    <= ctrm[5];
                        sz_q     <= sz;
                        off_q    <= off;
                        cnt      <= '0;
                        flush_q  <= 1'b0;
                    end else if (op_live) begin
                        yw      <= y;
                        irw     <= irm;
                        mdr     <= '0;
                        valid_w <= 1'b1;
                    end
                end
                ACCESS: begin
                    valid_w <= 1'b0;
                    if (done) begin
                        // A flushed access still finishes on the bus
                        if (!(flush_q || flush)) begin
                            valid_w <= 1'b1;
                            yw      <= y_q;
                            irw     <= ir_q;
                            mdr     <= st_q ? '0 : ld_ext;
                        end
                    end else if (tmo) begin
                        timeout_err <= 1'b1;
                        mdr         <= '0;
                    end else begin
                        cnt     <= cnt + 8'd1;
                        flush_q <= flush_q | flush;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: doc/mem_stage_ctrl.md
MEM_STAGE_CTRL -- requirements
Module: mem_stage_ctrl

Interface
REQ-001 Parameter DW, default 32, data and address width; legal values 32 and 64.
REQ-002 Parameter CTRL_W, default 32, control word width; minimum 6.
REQ-003 Parameter TIMEOUT, default 15, maximum wait cycles for dm_ready; legal range 1-255.
REQ-004 clk_cpu  in  1  CPU clock; all state updates on the rising edge.
REQ-005 rst  in  1  reset; asynchronous, active-high.
REQ-006 valid_m  in  1  MEM-stage instruction valid.
REQ-007 ctrm  in  CTRL_W  control: [1] load, [2] store, [4:3] size (00 byte, 01 half, 10 word, 11 dword when DW=64), [5] unsigned load.
REQ-008 y  in  DW  ALU result, used as the memory address.
REQ-009 mdw  in  DW  store data, right-aligned.
REQ-010 irm  in  32  instruction word in MEM.
REQ-011 flush  in  1  kill the current MEM instruction.
REQ-012 dm_rdata  in  DW  data-memory read data, valid when dm_ready=1.
REQ-013 dm_ready  in  1  data-memory access complete.
REQ-014 dm_req  out  1  data-memory request.
REQ-015 dm_we  out  1  data-memory write enable.
REQ-016 dm_be  out  DW/8  byte enables.
REQ-017 dm_addr  out  DW  registered address, word-aligned (low log2(DW/8) bits cleared).
REQ-018 dm_wdata  out  DW  lane-replicated store data.
REQ-019 mdr, yw  out  DW  load result and ALU result to WB.
REQ-020 irw  out  32  instruction word to WB.
REQ-021 valid_w  out  1  WB instruction valid.
REQ-022 stall_m  out  1  hold the upstream stages.
REQ-023 misalign, timeout_err  out  1  one-cycle error pulses.

Function
REQ-024 FSM states: IDLE and ACCESS.
REQ-025 IDLE, valid_m=1, flush=0, no load or store: on the next edge yw<=y, irw<=irm, mdr<=0, valid_w<=1; latency 1 cycle; stall_m=0.
REQ-026 IDLE, valid_m=0 or flush=1: on the next edge valid_w<=0; yw, irw and mdr hold.
REQ-027 IDLE with a load or store where y is not size-aligned (half: y[0]; word: y[1:0]; dword: y[2:0]): no request is made; misalign pulses on the next edge; valid_w<=0; mdr<=0.
REQ-028 IDLE with an aligned load or store: on the next edge, register the address, byte enables, write data, irm, y and the load attributes, then enter ACCESS.
REQ-029 stall_m is combinational: 1 in IDLE when an aligned memory op is present; 1 in ACCESS; 0 in the ACCESS cycle where dm_ready=1 or the timeout fires.
REQ-030 dm_req=1 exactly while in ACCESS.
REQ-031 dm_we=1 in ACCESS for a store, otherwise 0.
REQ-032 dm_be: byte gives one bit at the offset; half gives two bits at the offset; word gives four bits; dword gives all bits.
REQ-033 dm_wdata replicates the low byte or half of mdw across all lanes; word data is replicated for DW=64.
REQ-034 ACCESS with dm_ready=1: return to IDLE on the next edge with valid_w<=1, yw and irw taken from the registered copies.
REQ-035 Load completion: mdr <= dm_rdata shifted right by offset*8, truncated to size, then sign-extended (ctrm[5]=0) or zero-extended (ctrm[5]=1).
REQ-036 Store completion: mdr <= 0.
REQ-037 Wait counter: cleared on ACCESS entry, increments each ACCESS cycle with dm_ready=0.
REQ-038 Timeout: reaching TIMEOUT cycles with no ready returns the FSM to IDLE, pulses timeout_err, sets valid_w<=0 and mdr<=0.
REQ-039 flush during ACCESS does not abort the bus access; it is latched, and on completion valid_w<=0 and mdr, yw and irw hold.
REQ-040 dm_ready in the same cycle as the timeout threshold counts as completion; timeout_err stays 0.
REQ-041 dm_ready while in IDLE is ignored.
REQ-042 Inputs y, mdw, irm and ctrm are don't-care during ACCESS.

Reset
REQ-043 rst=1 asynchronously forces state IDLE, counter 0, flush latch 0, and all outputs and registered copies to 0 (dm_req, dm_we, dm_be, stall_m, valid_w, mdr, yw, irw, misalign, timeout_err).
REQ-044 rst asserted during ACCESS abandons the access; dm_req drops immediately and no WB result is produced.

Verification
REQ-045 Non-memory op, y=0x1234, irm=0x00A00093 -> next cycle yw=0x1234, irw=0x00A00093, mdr=0, valid_w=1, stall_m never 1.
REQ-046 Signed byte load at y=0x103, ready after 2 wait cycles, dm_rdata=0x80FF7F01 -> dm_be=1000; mdr=0xFFFFFF80; stall_m high 3 cycles.
REQ-047 Half store at y=0x202, mdw=0x0000BEEF -> dm_be=1100, dm_wdata=0xBEEFBEEF, dm_we=1, mdr=0, valid_w=1.
REQ-048 Word load at y=0x301 -> misalign pulses, dm_req stays 0, valid_w=0.
REQ-049 Load with dm_ready held 0, TIMEOUT=15 -> timeout_err pulses after 15 ACCESS cycles, FSM in IDLE, valid_w=0.
REQ-050 flush raised in the second ACCESS cycle, then ready -> access completes, valid_w=0; rst pulse mid-ACCESS -> all outputs 0 immediately.
